// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier.
// Contents:
//   state_t          - controller state encoding (binary, 2 bits)
//   cycleCountWidth  - width of the iteration counter for a given operand width
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_NEG  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // The counter must be able to hold WIDTH itself (oCycles after a full run).
    function automatic int unsigned cycleCountWidth(input int unsigned width);
        return unsigned'($clog2(width)) + 32'd1;
    endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Datapath of the shift-add multiplier: accumulator, multiplicand and
// multiplier registers, the adder, the shifters and the final negator.
// Ports:
//   Clock, Reset   rising-edge clock, synchronous active-high reset
//   iLoad          latch operand magnitudes, clear accumulator
//   iStep          one shift-add iteration
//   iNegate        two's-complement the accumulator
//   iSignedMode    operands are two's complement (sampled with iLoad)
//   iA, iB         multiplicand / multiplier
//   oAcc           current accumulator
//   oAccNext       accumulator value after the current edge
//   oNeg           result must be negated
//   oMultZero      multiplier is zero after the pending shift
module shift_add_datapath #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iLoad,
    input  logic               iStep,
    input  logic               iNegate,
    input  logic               iSignedMode,
    input  logic [WIDTH-1:0]   iA,
    input  logic [WIDTH-1:0]   iB,
    output logic [2*WIDTH-1:0] oAcc,
    output logic [2*WIDTH-1:0] oAccNext,
    output logic               oNeg,
    output logic               oMultZero
);

    logic [2*WIDTH-1:0] accQ, accD;
    logic [2*WIDTH-1:0] mcandQ, mcandD;
    logic [WIDTH-1:0]   multQ, multD;
    logic               negQ, negD;
    logic [WIDTH-1:0]   aMag, bMag;

    // -2^(W-1) negates to itself, which read as unsigned is its magnitude.
    always_comb begin
        aMag = (iSignedMode && iA[WIDTH-1]) ? -iA : iA;
        bMag = (iSignedMode && iB[WIDTH-1]) ? -iB : iB;
    end

    always_comb begin
        accD   = accQ;
        mcandD = mcandQ;
        multD  = multQ;
        negD   = negQ;
        if (iLoad) begin
            accD   = '0;
            mcandD = {{WIDTH{1'b0}}, aMag};
            multD  = bMag;
            negD   = iSignedMode & (iA[WIDTH-1] ^ iB[WIDTH-1]);
        end else if (iStep) begin
            // Magnitudes are < 2^W each, so the sum never carries out.
            if (multQ[0]) begin
                accD = accQ + mcandQ;
            end
            mcandD = mcandQ << 1;
            multD  = multQ >> 1;
        end else if (iNegate) begin
            accD = ~accQ + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            accQ   <= '0;
            mcandQ <= '0;
            multQ  <= '0;
            negQ   <= 1'b0;
        end else begin
            accQ   <= accD;
            mcandQ <= mcandD;
            multQ  <= multD;
            negQ   <= negD;
        end
    end

    assign oAcc      = accQ;
    assign oAccNext  = accD;
    assign oNeg      = negQ;
    assign oMultZero = (multQ >> 1) == '0;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential shift-add multiplier with valid/ack handshake.
// One multiplier bit is consumed per CALC cycle; an optional early exit
// fires once the remaining multiplier bits are all zero. Signed operands
// are multiplied as magnitudes and the product is negated in NEG.
// Ports:
//   Clock, Reset   rising-edge clock, synchronous active-high reset
//   iValid_Data    operands valid (taken only in IDLE)
//   iSigned        two's-complement operands (when SIGNED_EN)
//   iA, iB         multiplicand / multiplier
//   iAck           result consumed (acts only in DONE)
//   oBusy          high in CALC and NEG
//   oDone          high in DONE, oProduct valid
//   oProduct       2*WIDTH-bit product, updated on entry to DONE
//   oCycles        CALC iterations used by the last operation
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter bit          SIGNED_EN  = 1'b1,
    parameter bit          EARLY_TERM = 1'b1,
    localparam int unsigned CW        = cycleCountWidth(WIDTH)
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iValid_Data,
    input  logic               iSigned,
    input  logic [WIDTH-1:0]   iA,
    input  logic [WIDTH-1:0]   iB,
    input  logic               iAck,
    output logic               oBusy,
    output logic               oDone,
    output logic [2*WIDTH-1:0] oProduct,
    output logic [CW-1:0]      oCycles
);

    state_t             stateQ, stateD;
    logic [CW-1:0]      cntQ, cntD;
    logic [CW-1:0]      cyclesQ, cyclesD;
    logic [2*WIDTH-1:0] productQ, productD;

    logic               load, step, negate;
    logic               signedMode;
    logic [2*WIDTH-1:0] acc, accNext;
    logic               neg, multZero;

    assign signedMode = iSigned & SIGNED_EN;

    shift_add_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .Clock       (Clock),
        .Reset       (Reset),
        .iLoad       (load),
        .iStep       (step),
        .iNegate     (negate),
        .iSignedMode (signedMode),
        .iA          (iA),
        .iB          (iB),
        .oAcc        (acc),
        .oAccNext    (accNext),
        .oNeg        (neg),
        .oMultZero   (multZero)
    );

    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        cyclesD  = cyclesQ;
        productD = productQ;
        load     = 1'b0;
        step     = 1'b0;
        negate   = 1'b0;

        unique case (stateQ)
            ST_IDLE: begin
                if (iValid_Data) begin
                    load   = 1'b1;
                    cntD   = '0;
                    stateD = ST_CALC;
                end
            end
            ST_CALC: begin
                step = 1'b1;
                cntD = cntQ + CW'(1);
                if ((cntQ == CW'(WIDTH - 1)) || (EARLY_TERM && multZero)) begin
                    cyclesD = cntQ + CW'(1);
                    stateD  = neg ? ST_NEG : ST_DONE;
                end
            end
            ST_NEG: begin
                negate = 1'b1;
                stateD = ST_DONE;
            end
            ST_DONE: begin
                if (iAck) begin
                    stateD = ST_IDLE;
                end
            end
            default: stateD = ST_IDLE;
        endcase

        // Capture the final accumulator (including this edge's update) on entry to DONE.
        if (stateD == ST_DONE && stateQ != ST_DONE) begin
            productD = accNext;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            stateQ   <= ST_IDLE;
            cntQ     <= '0;
            cyclesQ  <= '0;
            productQ <= '0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            cyclesQ  <= cyclesD;
            productQ <= productD;
        end
    end

    assign oBusy    = (stateQ == ST_CALC) || (stateQ == ST_NEG);
    assign oDone    = (stateQ == ST_DONE);
    assign oProduct = productQ;
    assign oCycles  = cyclesQ;

    // acc is only consumed through accNext; keep it observable for debug.
    logic unusedAcc;
    assign unusedAcc = ^acc;

endmodule
